// File: rtl/lms_fifo_pkg.sv
// Shared constants and helpers for the LMS sample FIFO read-side engine.
package lms_fifo_pkg;

    localparam int FRAME_CNT_W   = 16;
    localparam int FRAME_LEN_MAX = 1 << FRAME_CNT_W;
    // Wide enough for the deepest skid buffer (latency 2 -> 3 entries).
    localparam int LEVEL_W       = 2;

    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

    function automatic bit rd_latency_legal(input int rd_latency);
        return (rd_latency == 1) || (rd_latency == 2);
    endfunction

endpackage

// File: rtl/lms_fifo_skid_buf.sv
// Small circular skid buffer: absorbs words already in flight from the FIFO
// so the read side can keep issuing while the consumer stalls.
module lms_fifo_skid_buf
    import lms_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               not_empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every *_d takes its *_q first, so no branch can leave a latch behind.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + LEVEL_W'(1);
            2'b01:   cnt_d = cnt_q - LEVEL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset (only DEPTH words) so m_data reads 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign not_empty = (cnt_q != '0);
    assign level     = cnt_q;

endmodule

// File: rtl/lms_fifo_reader.sv
// Read-side drain engine: issues FIFO reads, tracks the fixed read latency and
// streams samples out valid/ready. Define LMS_FIFO_RD_FRAME_EN for m_last framing.
module lms_fifo_reader
    import lms_fifo_pkg::*;
#(
    parameter int c_RD_DATA_WIDTH = 32,
    parameter int c_RD_LATENCY    = 1,
    parameter int c_FRAME_LEN     = 256
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic [c_RD_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       fifo_rd_empty,
    output logic                       fifo_rd_en,
    output logic                       fifo_rd_oce,
    output logic [c_RD_DATA_WIDTH-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic [LEVEL_W-1:0]         buf_level
);

    localparam int BUF_DEPTH = buf_depth(c_RD_LATENCY);
    localparam int SUM_W     = LEVEL_W + 1;

    if (!rd_latency_legal(c_RD_LATENCY) || (c_FRAME_LEN < 2) || (c_FRAME_LEN > FRAME_LEN_MAX))
    begin : g_param_check
        $error("lms_fifo_reader: c_RD_LATENCY must be 1 or 2, c_FRAME_LEN 2..65536");
    end

    logic [c_RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [SUM_W-1:0]        inflight_cnt;
    logic [SUM_W-1:0]        demand;
    logic                    capture;
    logic                    pop;

    assign pop         = m_valid && m_ready;
    assign capture     = inflight_q[c_RD_LATENCY-1];
    assign fifo_rd_oce = 1'b1;

    // A read is only issued if its word is guaranteed a slot on arrival.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(inflight_q[i]);
        end
        demand        = SUM_W'(buf_level) + inflight_cnt - SUM_W'(pop);
        fifo_rd_en    = !rd_rst && !fifo_rd_empty && (demand < SUM_W'(BUF_DEPTH));
        inflight_d    = inflight_q << 1;
        inflight_d[0] = fifo_rd_en;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    lms_fifo_skid_buf #(
        .WIDTH (c_RD_DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .wr_en     (capture),
        .wr_data   (fifo_rd_data),
        .rd_en     (pop),
        .rd_data   (m_data),
        .not_empty (m_valid),
        .level     (buf_level)
    );

`ifdef LMS_FIFO_RD_FRAME_EN
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(c_FRAME_LEN - 1);

    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pop) begin
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_last = m_valid && (frame_cnt_q == FRAME_LAST);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_lms_fifo_reader.sv
// Bench for lms_fifo_reader: latency-1 and latency-2 instances side by side,
// each fed by a behavioural FIFO, checked through a scoreboard monitor.
module tb_lms_fifo_reader;

    localparam int W        = 32;
    localparam int FL       = 4;
    localparam int FIFO_CAP = 16;
    localparam int N_RANDOM = 10000;
`ifdef LMS_FIFO_RD_FRAME_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         m_ready = 1'b0;
    logic [W-1:0] fifo_rd_data [2];
    logic [1:0]   fifo_rd_empty;
    logic [1:0]   fifo_rd_en;
    logic [1:0]   fifo_rd_oce;
    logic [W-1:0] m_data [2];
    logic [1:0]   m_valid;
    logic [1:0]   m_last;
    logic [1:0]   buf_level [2];

    always #5 clk = ~clk;

    lms_fifo_reader #(.c_RD_DATA_WIDTH(W), .c_RD_LATENCY(1), .c_FRAME_LEN(FL)) u_dut_lat1 (
        .rd_clk        (clk),
        .rd_rst        (rst),
        .fifo_rd_data  (fifo_rd_data[0]),
        .fifo_rd_empty (fifo_rd_empty[0]),
        .fifo_rd_en    (fifo_rd_en[0]),
        .fifo_rd_oce   (fifo_rd_oce[0]),
        .m_data        (m_data[0]),
        .m_valid       (m_valid[0]),
        .m_ready       (m_ready),
        .m_last        (m_last[0]),
        .buf_level     (buf_level[0])
    );

    lms_fifo_reader #(.c_RD_DATA_WIDTH(W), .c_RD_LATENCY(2), .c_FRAME_LEN(FL)) u_dut_lat2 (
        .rd_clk        (clk),
        .rd_rst        (rst),
        .fifo_rd_data  (fifo_rd_data[1]),
        .fifo_rd_empty (fifo_rd_empty[1]),
        .fifo_rd_en    (fifo_rd_en[1]),
        .fifo_rd_oce   (fifo_rd_oce[1]),
        .m_data        (m_data[1]),
        .m_valid       (m_valid[1]),
        .m_ready       (m_ready),
        .m_last        (m_last[1]),
        .buf_level     (buf_level[1])
    );

    // Behavioural FIFO contents and the scoreboard of words still owed downstream.
    logic [W-1:0] fq0[$], fq1[$], exp0[$], exp1[$];
    logic [W-1:0] pipe [2];
    logic [1:0]   rd_en_s;
    logic [1:0]   hold;
    int n_run, n_fail, cyc;
    int pushed [2];
    int pop_cnt [2];
    int first_rd [2], first_val [2], last_val [2], nval [2], nrd [2], nlast [2];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int fifo_size(input int d);
        return (d == 0) ? fq0.size() : fq1.size();
    endfunction

    function automatic int exp_size(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [W-1:0] exp_front(input int d);
        return (d == 0) ? exp0[0] : exp1[0];
    endfunction

    task automatic exp_pop(input int d);
        if (d == 0) void'(exp0.pop_front());
        else        void'(exp1.pop_front());
    endtask

    task automatic fifo_write(input int d, input logic [W-1:0] w);
        if (d == 0) begin
            fq0.push_back(w);
            exp0.push_back(w);
        end else begin
            fq1.push_back(w);
            exp1.push_back(w);
        end
        pushed[d]++;
        fifo_rd_empty[d] = 1'b0;
    endtask

    task automatic fifo_read(input int d, output logic [W-1:0] w);
        w = $urandom;
        if (d == 0) begin
            if (fq0.size() != 0) w = fq0.pop_front();
        end else begin
            if (fq1.size() != 0) w = fq1.pop_front();
        end
    endtask

    task automatic model_reset();
        fq0.delete();
        fq1.delete();
        exp0.delete();
        exp1.delete();
        rd_en_s       = '0;
        fifo_rd_empty = 2'b11;
        for (int d = 0; d < 2; d++) begin
            pipe[d]         = $urandom;
            fifo_rd_data[d] = $urandom;
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            first_rd[d]  = -1;
            first_val[d] = -1;
            last_val[d]  = -1;
            nval[d]      = 0;
            nrd[d]       = 0;
            nlast[d]     = 0;
        end
    endtask

    // One clock: observe at the falling edge, then advance the FIFO model just after the rising edge.
    task automatic cycle();
        logic [W-1:0] word;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rd_en_s[d] = fifo_rd_en[d];
            if (fifo_rd_en[d]) begin
                nrd[d]++;
                if (first_rd[d] < 0) first_rd[d] = cyc;
            end
            if (m_valid[d]) begin
                nval[d]++;
                last_val[d] = cyc;
                if (first_val[d] < 0) first_val[d] = cyc;
            end
            if (m_valid[d] && m_ready && m_last[d]) nlast[d]++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rd_en_s[d]) fifo_read(d, word);
            else            word = $urandom;
            if (d == 0) begin
                fifo_rd_data[0] = word;
            end else begin
                fifo_rd_data[1] = pipe[1];
                pipe[1]         = word;
            end
            fifo_rd_empty[d] = (fifo_size(d) == 0);
        end
        cyc++;
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_%s_rd_en", d + 1, tag), fifo_rd_en[d], 0);
            check($sformatf("lat%0d_%s_oce", d + 1, tag), fifo_rd_oce[d], 1);
            check($sformatf("lat%0d_%s_valid", d + 1, tag), m_valid[d], 0);
            check($sformatf("lat%0d_%s_data", d + 1, tag), m_data[d], 0);
            check($sformatf("lat%0d_%s_last", d + 1, tag), m_last[d], 0);
            check($sformatf("lat%0d_%s_level", d + 1, tag), buf_level[d], 0);
        end
    endtask

    // Scoreboard monitor: every presented word must be the oldest word still owed.
    initial begin
        hold    = '0;
        pop_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                pop_cnt = '{0, 0};
                hold    = '0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (fifo_rd_en[d]) check($sformatf("lat%0d_read_while_empty", d + 1), fifo_rd_empty[d], 0);
                    if (hold[d]) check($sformatf("lat%0d_valid_held", d + 1), m_valid[d], 1);
                    hold[d] = m_valid[d] && !m_ready;
                    if (m_valid[d]) begin
                        if (exp_size(d) == 0) begin
                            check($sformatf("lat%0d_valid_without_word", d + 1), m_valid[d], 0);
                        end else begin
                            check($sformatf("lat%0d_data", d + 1), m_data[d], exp_front(d));
                            check($sformatf("lat%0d_last", d + 1), m_last[d],
                                  FRAME_EN && ((pop_cnt[d] % FL) == FL - 1));
                            if (m_ready) begin
                                exp_pop(d);
                                pop_cnt[d]++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        n_run  = 0;
        n_fail = 0;
        cyc    = 0;
        pushed = '{0, 0};
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");

        // Four words sit in the FIFO through reset, then drain with m_ready high.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            for (int d = 0; d < 2; d++) fifo_write(d, W'(i));
        end
        cycle();
        for (int d = 0; d < 2; d++) check($sformatf("lat%0d_no_read_in_reset", d + 1), nrd[d], 0);
        rst     = 1'b0;
        m_ready = 1'b1;
        clear_stats();
        repeat (10) cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_first_word_latency", d + 1), first_val[d] - first_rd[d], d + 2);
            check($sformatf("lat%0d_words_seen", d + 1), nval[d], 4);
            check($sformatf("lat%0d_back_to_back", d + 1), last_val[d] - first_val[d], 3);
            check($sformatf("lat%0d_drained", d + 1), exp_size(d), 0);
        end

        // Consumer stalled with ten words available: only BUF_DEPTH reads may go out.
        m_ready = 1'b0;
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 2; d++) fifo_write(d, $urandom);
        end
        repeat (12) cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_stall_reads", d + 1), nrd[d], d + 2);
            check($sformatf("lat%0d_stall_level", d + 1), buf_level[d], d + 2);
        end
        m_ready = 1'b1;
        clear_stats();
        repeat (25) cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_release_words", d + 1), nval[d], 10);
            check($sformatf("lat%0d_release_no_bubble", d + 1), last_val[d] - first_val[d], 9);
            check($sformatf("lat%0d_release_drained", d + 1), exp_size(d), 0);
        end

        // Reset while reads are in flight; nothing from before may leak out afterwards.
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++) fifo_write(d, $urandom);
        end
        repeat (4) cycle();
        check("lat2_two_in_flight", rd_en_s[1], 1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Twelve fresh words after reset: frame marks fall on words 4, 8 and 12.
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 2; d++) fifo_write(d, 32'hA500_0000 | W'(i));
        end
        repeat (25) cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_frame_marks", d + 1), nlast[d], FRAME_EN ? 3 : 0);
            check($sformatf("lat%0d_frame_words", d + 1), nval[d], 12);
            check($sformatf("lat%0d_frame_drained", d + 1), exp_size(d), 0);
        end

        // Random consumer backpressure and random FIFO refill.
        pushed = '{0, 0};
        for (int c = 0; c < 60000 && (pushed[0] < N_RANDOM || pushed[1] < N_RANDOM); c++) begin
            m_ready = 1'($urandom_range(0, 1));
            for (int d = 0; d < 2; d++) begin
                if (pushed[d] < N_RANDOM && fifo_size(d) < FIFO_CAP && $urandom_range(0, 3) != 0)
                    fifo_write(d, $urandom);
            end
            cycle();
        end
        m_ready = 1'b1;
        for (int c = 0; c < 200 && (exp_size(0) != 0 || exp_size(1) != 0); c++) cycle();
        repeat (2) cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat%0d_random_words_issued", d + 1), pushed[d], N_RANDOM);
            check($sformatf("lat%0d_random_drained", d + 1), exp_size(d), 0);
            check($sformatf("lat%0d_random_final_level", d + 1), buf_level[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
